axi_register_bank: RTL and testbench

- Peripheral-side register file that sits directly downstream of the AXI slave interface block.
- Consumes its write/read request strobes, address, data and strobe outputs.
- Returns ready/busy/done/error and read data on the slave's peripheral-side inputs.
- Holds REG_COUNT 32-bit registers with byte-strobe writes, per-register read-only protection and a programmable access latency; all register contents are exported to the peripheral core.

---
 rtl/axi_register_bank.sv | 173 +++++++++++++++++
 tb/tb_axi_register_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_register_bank.sv
// Peripheral-side register bank behind the AXI slave: byte-strobe writes, per-register
// write protection, programmable access latency and independent read/write engines.
`timescale 1ns/1ps
module axi_register_bank #(
   parameter logic [31:0]          BASE_ADDRESS   = 32'h0000_0000,
   parameter int unsigned          REG_COUNT      = 8,
   parameter int unsigned          ACCESS_LATENCY = 1,
   parameter logic [REG_COUNT-1:0] READ_ONLY_MASK = '0
) (
   input  logic                      axi_ACLK,
   input  logic                      axi_ARESETN,
   input  logic                      write_request_i,
   input  logic [31:0]               write_address_i,
   input  logic [31:0]               write_data_i,
   input  logic [3:0]                write_strobe_i,
   output logic                      write_ready_o,
   output logic                      write_busy_o,
   output logic                      write_done_o,
   output logic                      write_error_o,
   input  logic                      read_request_i,
   input  logic [31:0]               read_address_i,
   output logic                      read_ready_o,
   output logic                      read_busy_o,
   output logic                      read_done_o,
   output logic                      read_error_o,
   output logic [31:0]               read_data_o,
   output logic [32*REG_COUNT-1:0]   registers_o
);

   localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      CNT_W'((ACCESS_LATENCY > 1) ? (ACCESS_LATENCY - 2) : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t           r_wr_state, r_rd_state;
   logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;
   logic             r_wr_busy, r_wr_done, r_wr_error, r_wr_err_lat;
   logic             r_rd_busy, r_rd_done, r_rd_error, r_rd_err_lat;
   logic [31:0]      r_rd_data;
   logic [31:0]      r_regs [REG_COUNT];

   logic [31:0]      w_wr_offset, w_rd_offset;
   logic [29:0]      w_wr_index, w_rd_index;
   logic [IDX_W-1:0] w_wr_sel, w_rd_sel;
   logic             w_wr_in_range, w_rd_in_range;
   logic             w_wr_error, w_rd_error;

   // Address decode; addresses below BASE wrap to huge offsets and fall out of range
   assign w_wr_offset   = write_address_i - BASE_ADDRESS;
   assign w_wr_index    = w_wr_offset[31:2];
   assign w_wr_sel      = w_wr_index[IDX_W-1:0];
   assign w_wr_in_range = (w_wr_index < 30'(REG_COUNT));
   assign w_wr_error    = (w_wr_offset[1:0] != 2'b00) | ~w_wr_in_range
                        | (w_wr_in_range & READ_ONLY_MASK[w_wr_sel]);

   assign w_rd_offset   = read_address_i - BASE_ADDRESS;
   assign w_rd_index    = w_rd_offset[31:2];
   assign w_rd_sel      = w_rd_index[IDX_W-1:0];
   assign w_rd_in_range = (w_rd_index < 30'(REG_COUNT));
   assign w_rd_error    = (w_rd_offset[1:0] != 2'b00) | ~w_rd_in_range;

   // Write engine: commits at the accepting edge, completion reported ACCESS_LATENCY later
   always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
      if (!axi_ARESETN) begin
         r_wr_state   <= ST_IDLE;
         r_wr_cnt     <= '0;
         r_wr_busy    <= 1'b0;
         r_wr_done    <= 1'b0;
         r_wr_error   <= 1'b0;
         r_wr_err_lat <= 1'b0;
         for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      end else begin
         r_wr_done  <= 1'b0;
         r_wr_error <= 1'b0;
         case (r_wr_state)
            ST_IDLE: if (write_request_i) begin
               r_wr_busy    <= 1'b1;
               r_wr_err_lat <= w_wr_error;
               if (!w_wr_error) begin
                  for (int unsigned k = 0; k < 4; k++)
                     if (write_strobe_i[k]) r_regs[w_wr_sel][8*k +: 8] <= write_data_i[8*k +: 8];
               end
               if (ACCESS_LATENCY > 1) begin
                  r_wr_state <= ST_WAIT;
                  r_wr_cnt   <= WAIT_LOAD;
               end else begin
                  r_wr_state <= ST_DONE;
                  r_wr_done  <= 1'b1;
                  r_wr_error <= w_wr_error;
               end
            end
            ST_WAIT: if (r_wr_cnt == '0) begin
               r_wr_state <= ST_DONE;
               r_wr_done  <= 1'b1;
               r_wr_error <= r_wr_err_lat;
            end else begin
               r_wr_cnt <= r_wr_cnt - CNT_W'(1);
            end
            ST_DONE: begin
               r_wr_state <= ST_IDLE;
               r_wr_busy  <= 1'b0;
            end
            default: r_wr_state <= ST_IDLE;
         endcase
      end
   end

   // Read engine: snapshot taken at the accepting edge, held until the next accepted read
   always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
      if (!axi_ARESETN) begin
         r_rd_state   <= ST_IDLE;
         r_rd_cnt     <= '0;
         r_rd_busy    <= 1'b0;
         r_rd_done    <= 1'b0;
         r_rd_error   <= 1'b0;
         r_rd_err_lat <= 1'b0;
         r_rd_data    <= '0;
      end else begin
         r_rd_done  <= 1'b0;
         r_rd_error <= 1'b0;
         case (r_rd_state)
            ST_IDLE: if (read_request_i) begin
               r_rd_busy    <= 1'b1;
               r_rd_err_lat <= w_rd_error;
               r_rd_data    <= w_rd_error ? 32'h0 : r_regs[w_rd_sel];
               if (ACCESS_LATENCY > 1) begin
                  r_rd_state <= ST_WAIT;
                  r_rd_cnt   <= WAIT_LOAD;
               end else begin
                  r_rd_state <= ST_DONE;
                  r_rd_done  <= 1'b1;
                  r_rd_error <= w_rd_error;
               end
            end
            ST_WAIT: if (r_rd_cnt == '0) begin
               r_rd_state <= ST_DONE;
               r_rd_done  <= 1'b1;
               r_rd_error <= r_rd_err_lat;
            end else begin
               r_rd_cnt <= r_rd_cnt - CNT_W'(1);
            end
            ST_DONE: begin
               r_rd_state <= ST_IDLE;
               r_rd_busy  <= 1'b0;
            end
            default: r_rd_state <= ST_IDLE;
         endcase
      end
   end

   // Ready drops in the request cycle to cover the slave's registered-ready lag
   assign write_ready_o = (r_wr_state == ST_IDLE) & ~write_request_i;
   assign read_ready_o  = (r_rd_state == ST_IDLE) & ~read_request_i;
   assign write_busy_o  = r_wr_busy;
   assign write_done_o  = r_wr_done;
   assign write_error_o = r_wr_error;
   assign read_busy_o   = r_rd_busy;
   assign read_done_o   = r_rd_done;
   assign read_error_o  = r_rd_error;
   assign read_data_o   = r_rd_data;

   for (genvar g = 0; g < REG_COUNT; g++) begin : g_export
      assign registers_o[32*g +: 32] = r_regs[g];
   end

   a_wr_req_idle: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
      write_request_i |-> (r_wr_state == ST_IDLE));
   a_rd_req_idle: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
      read_request_i |-> (r_rd_state == ST_IDLE));

endmodule

// File: tb/tb_axi_register_bank.sv
// Directed bench: latency-1 (a_*) and latency-4 (b_*) banks share stimulus, BASE=0x1000,
// register 0 write-protected.
`timescale 1ns/1ps
module tb_axi_register_bank;

   localparam int unsigned NREG = 8;
   localparam int unsigned NV   = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wr_req = 1'b0, rd_req = 1'b0;
   logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
   logic [3:0]  wr_strb = '0;

   logic a_wr_ready, a_wr_busy, a_wr_done, a_wr_err;
   logic a_rd_ready, a_rd_busy, a_rd_done, a_rd_err;
   logic b_wr_ready, b_wr_busy, b_wr_done, b_wr_err;
   logic b_rd_ready, b_rd_busy, b_rd_done, b_rd_err;
   logic [31:0] a_rd_data, b_rd_data;
   logic [32*NREG-1:0] a_regs, b_regs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_register_bank #(.BASE_ADDRESS(32'h1000), .REG_COUNT(NREG), .ACCESS_LATENCY(1),
                       .READ_ONLY_MASK(8'h01)) u_a (
      .axi_ACLK(clk), .axi_ARESETN(rst_n),
      .write_request_i(wr_req), .write_address_i(wr_addr), .write_data_i(wr_data),
      .write_strobe_i(wr_strb), .write_ready_o(a_wr_ready), .write_busy_o(a_wr_busy),
      .write_done_o(a_wr_done), .write_error_o(a_wr_err),
      .read_request_i(rd_req), .read_address_i(rd_addr), .read_ready_o(a_rd_ready),
      .read_busy_o(a_rd_busy), .read_done_o(a_rd_done), .read_error_o(a_rd_err),
      .read_data_o(a_rd_data), .registers_o(a_regs));

   axi_register_bank #(.BASE_ADDRESS(32'h1000), .REG_COUNT(NREG), .ACCESS_LATENCY(4),
                       .READ_ONLY_MASK(8'h01)) u_b (
      .axi_ACLK(clk), .axi_ARESETN(rst_n),
      .write_request_i(wr_req), .write_address_i(wr_addr), .write_data_i(wr_data),
      .write_strobe_i(wr_strb), .write_ready_o(b_wr_ready), .write_busy_o(b_wr_busy),
      .write_done_o(b_wr_done), .write_error_o(b_wr_err),
      .read_request_i(rd_req), .read_address_i(rd_addr), .read_ready_o(b_rd_ready),
      .read_busy_o(b_rd_busy), .read_done_o(b_rd_done), .read_error_o(b_rd_err),
      .read_data_o(b_rd_data), .registers_o(b_regs));

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int unsigned reg_idx;
      logic [31:0] exp_reg;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] reg_of(input logic [32*NREG-1:0] flat, input int unsigned i);
      return flat[32*i +: 32];
   endfunction

   task automatic check_idle_regs_zero(input string tag);
      check({tag, " a_wr_ready"}, 32'(a_wr_ready), 32'd1);
      check({tag, " a_rd_ready"}, 32'(a_rd_ready), 32'd1);
      check({tag, " b_wr_ready"}, 32'(b_wr_ready), 32'd1);
      check({tag, " b_rd_ready"}, 32'(b_rd_ready), 32'd1);
      check({tag, " busy/done/err"}, 32'({a_wr_busy, a_wr_done, a_wr_err, a_rd_busy, a_rd_done,
            a_rd_err, b_wr_busy, b_wr_done, b_wr_err, b_rd_busy, b_rd_done, b_rd_err}), 32'd0);
      check({tag, " a_rd_data"}, a_rd_data, 32'h0);
      check({tag, " b_rd_data"}, b_rd_data, 32'h0);
      for (int unsigned i = 0; i < NREG; i++) begin
         check($sformatf("%s a_reg%0d", tag, i), reg_of(a_regs, i), 32'h0);
         check($sformatf("%s b_reg%0d", tag, i), reg_of(b_regs, i), 32'h0);
      end
   endtask

   initial begin
      logic [31:0] last_rd;
      vec_t v;
      string s;

      vecs[0]  = '{1'b1, 32'h1008, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0, 2, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 32'h1008, 32'h000000AA, 4'b0001, 1'b0, 32'h0, 2, 32'hDEADBEAA};
      vecs[2]  = '{1'b0, 32'h1008, 32'h0,        4'b0000, 1'b0, 32'hDEADBEAA, 2, 32'hDEADBEAA};
      vecs[3]  = '{1'b1, 32'h1002, 32'h12345678, 4'b1111, 1'b1, 32'h0, 2, 32'hDEADBEAA};
      vecs[4]  = '{1'b0, 32'h1020, 32'h0,        4'b0000, 1'b1, 32'h0, 2, 32'hDEADBEAA};
      vecs[5]  = '{1'b1, 32'h0FFC, 32'h55555555, 4'b1111, 1'b1, 32'h0, 7, 32'h0};
      vecs[6]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0, 0, 32'h0};
      vecs[7]  = '{1'b1, 32'h1004, 32'h00000003, 4'b1111, 1'b0, 32'h0, 1, 32'h3};
      vecs[8]  = '{1'b1, 32'h100C, 32'h11223344, 4'b0000, 1'b0, 32'h0, 3, 32'h0};
      vecs[9]  = '{1'b1, 32'h100C, 32'h11223344, 4'b1010, 1'b0, 32'h0, 3, 32'h11003300};
      vecs[10] = '{1'b0, 32'h100C, 32'h0,        4'b0000, 1'b0, 32'h11003300, 3, 32'h11003300};
      vecs[11] = '{1'b0, 32'h1000, 32'h0,        4'b0000, 1'b0, 32'h0, 0, 32'h0};
      vecs[12] = '{1'b1, 32'h101C, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0, 7, 32'hCAFEF00D};
      vecs[13] = '{1'b0, 32'h101C, 32'h0,        4'b0000, 1'b0, 32'hCAFEF00D, 7, 32'hCAFEF00D};
      vecs[14] = '{1'b0, 32'h1001, 32'h0,        4'b0000, 1'b1, 32'h0, 2, 32'hDEADBEAA};

      repeat (3) @(negedge clk);
      check_idle_regs_zero("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_regs_zero("post_reset");
      last_rd = 32'h0;

      for (int n = 0; n < NV; n++) begin
         v = vecs[n];
         s = $sformatf("v%0d", n);
         @(negedge clk);
         wr_req = v.is_wr;  rd_req = ~v.is_wr;
         wr_addr = v.addr;  rd_addr = v.addr;
         wr_data = v.data;  wr_strb = v.strb;
         #1;
         check({s, " ready_drop"}, 32'(v.is_wr ? a_wr_ready : a_rd_ready), 32'd0);
         check({s, " other_ready"}, 32'(v.is_wr ? a_rd_ready : a_wr_ready), 32'd1);
         @(negedge clk);  // t+1
         wr_req = 1'b0;  rd_req = 1'b0;
         check({s, " a_done"}, 32'(v.is_wr ? a_wr_done : a_rd_done), 32'd1);
         check({s, " a_err"},  32'(v.is_wr ? a_wr_err  : a_rd_err),  32'(v.exp_err));
         check({s, " b_busy"}, 32'(v.is_wr ? b_wr_busy : b_rd_busy), 32'd1);
         check({s, " b_done_early"}, 32'(v.is_wr ? b_wr_done : b_rd_done), 32'd0);
         if (!v.is_wr) last_rd = v.exp_rdata;
         check({s, " a_rd_data"}, a_rd_data, last_rd);
         check({s, " b_rd_data"}, b_rd_data, last_rd);
         check({s, " a_reg"}, reg_of(a_regs, v.reg_idx), v.exp_reg);
         check({s, " b_reg"}, reg_of(b_regs, v.reg_idx), v.exp_reg);
         @(negedge clk);  // t+2
         check({s, " a_back_idle"}, 32'({a_wr_busy, a_wr_done, a_rd_busy, a_rd_done}), 32'd0);
         repeat (2) @(negedge clk);  // t+4
         check({s, " b_done"}, 32'(v.is_wr ? b_wr_done : b_rd_done), 32'd1);
         check({s, " b_err"},  32'(v.is_wr ? b_wr_err  : b_rd_err),  32'(v.exp_err));
         @(negedge clk);  // t+5
         check({s, " b_back_idle"}, 32'({b_wr_busy, b_wr_done, b_rd_busy, b_rd_done}), 32'd0);
      end

      // Latency-4 read: busy t+1..t+4, single done at t+4, data held through t+10
      @(negedge clk);
      rd_req = 1'b1;  rd_addr = 32'h1008;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         rd_req = 1'b0;
         check($sformatf("lat4 busy t+%0d", k), 32'(b_rd_busy), 32'(k <= 4));
         check($sformatf("lat4 done t+%0d", k), 32'(b_rd_done), 32'(k == 4));
         check($sformatf("lat4 data t+%0d", k), b_rd_data, 32'hDEADBEAA);
      end

      // Same-cycle write and read of register 1 (holding 3): read sees old value
      @(negedge clk);
      wr_req = 1'b1;  wr_addr = 32'h1004;  wr_data = 32'h5;  wr_strb = 4'b1111;
      rd_req = 1'b1;  rd_addr = 32'h1004;
      @(negedge clk);
      wr_req = 1'b0;  rd_req = 1'b0;
      check("simul a both_done", 32'({a_wr_done, a_rd_done, a_wr_err, a_rd_err}), 32'b1100);
      check("simul a rd_data", a_rd_data, 32'h3);
      check("simul a reg1", reg_of(a_regs, 1), 32'h5);
      check("simul b reg1", reg_of(b_regs, 1), 32'h5);
      repeat (3) @(negedge clk);
      check("simul b both_done", 32'({b_wr_done, b_rd_done, b_wr_err, b_rd_err}), 32'b1100);
      check("simul b rd_data", b_rd_data, 32'h3);
      @(negedge clk);

      // Reset during a latency-4 write WAIT: everything back to reset values, no done later
      @(negedge clk);
      wr_req = 1'b1;  wr_addr = 32'h1010;  wr_data = 32'h77;  wr_strb = 4'b1111;
      @(negedge clk);
      wr_req = 1'b0;
      check("rst b reg4 committed", reg_of(b_regs, 4), 32'h77);
      @(negedge clk);
      check("rst b busy in wait", 32'(b_wr_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_regs_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("post_rst no_done %0d", k), 32'({a_wr_done, b_wr_done, b_wr_busy}), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
